mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
Multicycle MIPS main controller: the producer end of the ALU control/operand interface. Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. Drives alucontrol, ALU source muxes, PC/IR/memory/register-file enables from IR opcode/funct and the ALU zero flag. Sits beside the datapath in the DBG build and exports its state for the debug probe.

Parameters:
ILLEGAL_TRAP, 0, 0: unsupported opcode/funct returns to FETCH as a NOP; 1: enter HALT until reset.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous reset, active-low
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pcen  out  1  PC load enable = pcwrite | (branch & zero)
iord  out  1  memory address: 0=PC, 1=ALUOut
memwrite  out  1  data memory write
irwrite  out  1  instruction register load
regdst  out  1  write register: 0=rt, 1=rd
memtoreg  out  1  writeback: 0=ALUOut, 1=Data
regwrite  out  1  register file write
alusrca  out  1  ALU A: 0=PC, 1=A reg
alusrcb  out  2  ALU B: 00=B reg, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  PC next: 00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
halted  out  1  1 in HALT
state  out  4  current state code, debug

Behaviour:
- Reset: reset_n low asynchronously forces state=FETCH (0). While reset_n=0, pcen, irwrite, memwrite and regwrite are forced to 0; the other outputs hold their FETCH values. Release takes effect at the next rising clk.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 15.
- Outputs are a function of state only, except alucontrol in RTYPEEX (from funct) and pcen (uses zero). Any output not listed for a state is 0.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (precomputes the branch target).
  - opcode 100011 (lw) or 101011 (sw) -> MEMADR
  - opcode 000000 with a supported funct -> RTYPEEX
  - opcode 000100 (beq) -> BEQEX
  - opcode 001000 (addi) -> ADDIEX
  - opcode 000010 (j) -> JEX
  - anything else -> FETCH if ILLEGAL_TRAP=0, otherwise HALT
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state: FETCH.
- MEMWR: iord=1, memwrite=1. Next state: FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. funct maps to alucontrol: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next state: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state: FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Next state: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next state: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state: FETCH.
- HALT: all enables 0, halted=1. Stays in HALT until reset_n.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- An unreachable state code goes to FETCH on the next clk. Reset mid-instruction aborts it and no enables fire.

Optional Feature:
MC_BNE_EN: when defined, opcode 000101 (bne) in DECODE goes to BNEEX (code 12). BNEEX has the BEQEX outputs plus an internal bne=1, and pcen = pcwrite | (branch & zero) | (bne & ~zero). When undefined, 000101 is handled as an illegal opcode.

Test Plan:
- Reset held low 3 cycles, then released -> state=0, pcen/irwrite/memwrite/regwrite=0 during reset; first cycle after release: pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
- lw (opcode 100011) -> state sequence 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1, regdst=0.
- R-type funct 101010 then 100010 -> RTYPEEX alucontrol=111 then 110; RTYPEWB regdst=1, regwrite=1; 4 cycles each.
- beq with zero=1, then zero=0 -> BEQEX pcen=1 then 0; pcsrc=01, alucontrol=110.
- Opcode 111111 with ILLEGAL_TRAP=0 -> 0,1,0 with no write enables; with ILLEGAL_TRAP=1 -> state=15, halted=1 held 10 cycles until reset_n.
- With MC_BNE_EN, opcode 000101, zero=0 -> state 12, pcen=1; zero=1 -> pcen=0.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller (Moore FSM); MC_BNE_EN adds the bne execute state.
// Latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles per instruction.
// No backpressure: advances every clk; HALT (ILLEGAL_TRAP=1) is left only through reset_n.
module mips_mc_control #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12,
        HALT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       rtype;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       halted;
    } ctrl_t;

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] a;
        a = 3'b010;
        case (f)
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default:   a = 3'b010;
        endcase
        return a;
    endfunction

    // Control word for a state; registered alongside the state so outputs come straight from flops.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.aluop   = 3'b010;
                c.pcwrite = 1'b1;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                c.aluop   = 3'b010;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = 3'b010;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.rtype   = 1'b1;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b110;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b110;
                c.pcsrc   = 2'b01;
                c.bne     = 1'b1;
            end
`endif
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = 3'b010;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (opcode)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000: nxt = funct_ok(funct) ? RTYPEEX
                                   : ((ILLEGAL_TRAP != 0) ? HALT : FETCH);
                    6'b000100: nxt = BEQEX;
                    6'b001000: nxt = ADDIEX;
                    6'b000010: nxt = JEX;
`ifdef MC_BNE_EN
                    6'b000101: nxt = BNEEX;
`endif
                    default:   nxt = (ILLEGAL_TRAP != 0) ? HALT : FETCH;
                endcase
            end
            MEMADR:  nxt = (opcode == 6'b101011) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= FETCH;
            ctrl <= decode(FETCH);
        end else begin
            cur  <= nxt;
            ctrl <= decode(nxt);
        end
    end

    // Write enables are gated by reset_n so nothing fires while reset is asserted.
    assign pcen       = reset_n & (ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.bne & ~zero));
    assign irwrite    = reset_n & ctrl.irwrite;
    assign memwrite   = reset_n & ctrl.memwrite;
    assign regwrite   = reset_n & ctrl.regwrite;
    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign alucontrol = ctrl.rtype ? funct_alu(funct) : ctrl.aluop;
    assign halted     = ctrl.halted;
    assign state      = cur;

endmodule
